// File: rtl/equihash_result_tx_if.sv
// Verifier result mask type and the AXI-stream bundle used by the Equihash reply path.
package equihash_result_tx_pkg;
   typedef struct packed {
      logic [4:0] rsvd;
      logic       xor_fail;
      logic       order_fail;
      logic       dup_fail;
   } equihash_bm_t;
endpackage

interface if_axi_stream #(parameter int unsigned BYTS = 8);
   localparam int unsigned DAT_W = BYTS * 8;
   localparam int unsigned MOD_W = (BYTS > 1) ? $clog2(BYTS) : 1;
   localparam int unsigned CTL_W = 8;

   logic             val;
   logic             sop;
   logic             eop;
   logic             err;
   logic             rdy;
   logic [CTL_W-1:0] ctl;
   logic [MOD_W-1:0] mod;
   logic [DAT_W-1:0] dat;

   modport master (output val, sop, eop, err, ctl, mod, dat, input rdy);
   modport slave  (input val, sop, eop, err, ctl, mod, dat, output rdy);
endinterface

// File: rtl/equihash_result_tx.sv
// Serialises verifier results into 2-beat reply packets (header + mask) with a
// 2-deep result buffer; results arriving with both slots occupied are dropped and counted.
module equihash_result_tx
   import equihash_result_tx_pkg::*;
#(
   parameter int unsigned DAT_BYTS  = 8,
   parameter int unsigned MASK_BITS = $bits(equihash_bm_t),
   parameter logic [15:0] MSG_TYPE  = 16'h0101
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [MASK_BITS-1:0] i_mask,
   input  logic                 i_mask_val,
   if_axi_stream.master         o_axi,
   output logic                 o_busy,
   output logic [7:0]           o_drop_cnt
);
   localparam int unsigned DAT_W = DAT_BYTS * 8;
   localparam int unsigned TAG_W = 32;

   if (DAT_BYTS != 8) begin : g_bad_bytes
      $fatal(1, "equihash_result_tx: only DAT_BYTS=8 is supported");
   end
   if (MASK_BITS > 64) begin : g_bad_mask
      $fatal(1, "equihash_result_tx: MASK_BITS must be <= 64");
   end

   typedef enum logic [1:0] {IDLE, HDR, MASK} state_t;

   state_t               state_q,    state_d;
   logic [MASK_BITS-1:0] act_mask_q, act_mask_d;
   logic [TAG_W-1:0]     act_tag_q,  act_tag_d;
   logic                 pend_vld_q, pend_vld_d;
   logic [MASK_BITS-1:0] pend_mask_q, pend_mask_d;
   logic [TAG_W-1:0]     pend_tag_q, pend_tag_d;
   logic [TAG_W-1:0]     seq_q,      seq_d;
   logic [7:0]           drop_q,     drop_d;
   logic                 val_q, val_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
   logic [DAT_W-1:0]     dat_q,      dat_d;
   logic                 busy_q,     busy_d;

   logic xfer_c, retire_c, act_free_c, pend_free_c;

   // Next-state, slot allocation and registered beat contents
   always_comb begin
      state_d     = state_q;
      act_mask_d  = act_mask_q;
      act_tag_d   = act_tag_q;
      pend_vld_d  = pend_vld_q;
      pend_mask_d = pend_mask_q;
      pend_tag_d  = pend_tag_q;
      seq_d       = seq_q;
      drop_d      = drop_q;

      xfer_c      = val_q & o_axi.rdy;
      retire_c    = (state_q == MASK) & xfer_c;
      act_free_c  = (state_q == IDLE) | (retire_c & ~pend_vld_q);
      pend_free_c = ~pend_vld_q | retire_c;

      case (state_q)
         HDR:     if (xfer_c) state_d = MASK;
         MASK: begin
            if (retire_c) begin
               if (pend_vld_q) begin
                  act_mask_d = pend_mask_q;
                  act_tag_d  = pend_tag_q;
                  pend_vld_d = 1'b0;
                  state_d    = HDR;
               end else begin
                  state_d    = IDLE;
               end
            end
         end
         default: ;
      endcase

      if (i_mask_val) begin
         if (act_free_c) begin
            act_mask_d = i_mask;
            act_tag_d  = seq_q;
            seq_d      = seq_q + TAG_W'(1);
            state_d    = HDR;
         end else if (pend_free_c) begin
            pend_mask_d = i_mask;
            pend_tag_d  = seq_q;
            pend_vld_d  = 1'b1;
            seq_d       = seq_q + TAG_W'(1);
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end

      val_d  = (state_d != IDLE);
      sop_d  = (state_d == HDR);
      eop_d  = (state_d == MASK);
      err_d  = (state_d == MASK) & (|act_mask_d);
      dat_d  = (state_d == HDR) ? DAT_W'({act_tag_d, 16'd16, MSG_TYPE}) : DAT_W'(act_mask_d);
      busy_d = (state_d != IDLE) | pend_vld_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         act_mask_q  <= '0;
         act_tag_q   <= '0;
         pend_vld_q  <= 1'b0;
         pend_mask_q <= '0;
         pend_tag_q  <= '0;
         seq_q       <= '0;
         drop_q      <= '0;
         val_q       <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         err_q       <= 1'b0;
         dat_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_mask_q  <= act_mask_d;
         act_tag_q   <= act_tag_d;
         pend_vld_q  <= pend_vld_d;
         pend_mask_q <= pend_mask_d;
         pend_tag_q  <= pend_tag_d;
         seq_q       <= seq_d;
         drop_q      <= drop_d;
         val_q       <= val_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         err_q       <= err_d;
         dat_q       <= dat_d;
         busy_q      <= busy_d;
      end
   end

   assign o_axi.val  = val_q;
   assign o_axi.sop  = sop_q;
   assign o_axi.eop  = eop_q;
   assign o_axi.err  = err_q;
   assign o_axi.dat  = dat_q;
   assign o_axi.ctl  = '0;
   assign o_axi.mod  = '0;
   assign o_busy     = busy_q;
   assign o_drop_cnt = drop_q;
endmodule

// File: tb/tb_equihash_result_tx.sv
// Directed bench for equihash_result_tx: single-packet vector table plus buffering,
// drop, wrap and reset corner sequences.
module tb_equihash_result_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] i_mask = '0;
   logic       i_mask_val = 1'b0;
   logic       o_busy;
   logic [7:0] o_drop_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] next_tag = '0;

   if_axi_stream #(.BYTS(8)) axi ();

   equihash_result_tx dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_mask     (i_mask),
      .i_mask_val (i_mask_val),
      .o_axi      (axi),
      .o_busy     (o_busy),
      .o_drop_cnt (o_drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  mask;
      int          stall;
      logic [63:0] exp_dat1;
      logic        exp_err;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] hdr(input logic [31:0] tag);
      logic [63:0] h;
      h = {tag, 16'h0010, 16'h0101};
      return h;
   endfunction

   // One-cycle strobe; returns at the negedge right after the capture edge
   task automatic strobe(input logic [7:0] m);
      @(negedge clk);
      i_mask     = m;
      i_mask_val = 1'b1;
      @(negedge clk);
      i_mask_val = 1'b0;
   endtask

   // Receives both beats of one packet with rdy assumed high
   task automatic get_pkt(input logic [31:0] tag, input logic [63:0] dat1, input logic err1);
      int w = 0;
      while (axi.val !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("pkt_timeout", 64'(w < 50), 64'd1);
      chk("b0_sop", 64'(axi.sop), 64'd1);
      chk("b0_eop", 64'(axi.eop), 64'd0);
      chk("b0_err", 64'(axi.err), 64'd0);
      chk("b0_dat", axi.dat, hdr(tag));
      @(negedge clk);
      chk("b1_val", 64'(axi.val), 64'd1);
      chk("b1_sop", 64'(axi.sop), 64'd0);
      chk("b1_eop", 64'(axi.eop), 64'd1);
      chk("b1_err", 64'(axi.err), 64'(err1));
      chk("b1_dat", axi.dat, dat1);
      chk("mod_ctl", 64'({axi.mod, axi.ctl}), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      vt[0] = '{mask: 8'h00, stall: 0,  exp_dat1: 64'h0000_0000_0000_0000, exp_err: 1'b0};
      vt[1] = '{mask: 8'h04, stall: 10, exp_dat1: 64'h0000_0000_0000_0004, exp_err: 1'b1};
      vt[2] = '{mask: 8'h01, stall: 0,  exp_dat1: 64'h0000_0000_0000_0001, exp_err: 1'b1};
      vt[3] = '{mask: 8'h80, stall: 3,  exp_dat1: 64'h0000_0000_0000_0080, exp_err: 1'b1};
      vt[4] = '{mask: 8'hFF, stall: 1,  exp_dat1: 64'h0000_0000_0000_00FF, exp_err: 1'b1};
      axi.rdy = 1'b0;

      #12;
      chk("rst_val", 64'(axi.val), 64'd0);
      chk("rst_flags", 64'({axi.sop, axi.eop, axi.err}), 64'd0);
      chk("rst_dat", axi.dat, 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_drop", 64'(o_drop_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single-packet table, optionally stalled before acceptance
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         axi.rdy = (vt[i].stall == 0);
         strobe(vt[i].mask);
         chk("latency_val", 64'(axi.val), 64'd1);
         for (int s = 0; s < vt[i].stall; s++) begin
            chk("stall_val", 64'(axi.val), 64'd1);
            chk("stall_sop", 64'(axi.sop), 64'd1);
            chk("stall_dat", axi.dat, hdr(next_tag));
            @(negedge clk);
         end
         axi.rdy = 1'b1;
         get_pkt(next_tag, vt[i].exp_dat1, vt[i].exp_err);
         next_tag++;
         chk("idle_busy", 64'(o_busy), 64'd0);
         chk("idle_val", 64'(axi.val), 64'd0);
      end

      // Buffer full: third result dropped, two packets back-to-back
      axi.rdy = 1'b0;
      strobe(8'h11);
      strobe(8'h22);
      strobe(8'h33);
      chk("drop_cnt1", 64'(o_drop_cnt), 64'd1);
      chk("busy_full", 64'(o_busy), 64'd1);
      axi.rdy = 1'b1;
      get_pkt(next_tag, 64'h11, 1'b1);
      chk("b2b_val", 64'(axi.val), 64'd1);
      chk("b2b_sop", 64'(axi.sop), 64'd1);
      get_pkt(next_tag + 32'd1, 64'h22, 1'b1);
      next_tag += 32'd2;
      repeat (3) @(negedge clk);
      chk("no_third", 64'(axi.val), 64'd0);
      chk("drop_hold", 64'(o_drop_cnt), 64'd1);

      // Strobe coincident with beat1 retire while pending is full
      axi.rdy = 1'b0;
      strobe(8'h41);
      strobe(8'h42);
      axi.rdy = 1'b1;
      chk("co_b0", axi.dat, hdr(next_tag));
      @(negedge clk);
      chk("co_b1_eop", 64'(axi.eop), 64'd1);
      i_mask     = 8'h43;
      i_mask_val = 1'b1;
      @(negedge clk);
      i_mask_val = 1'b0;
      get_pkt(next_tag + 32'd1, 64'h42, 1'b1);
      chk("co_b2b_sop", 64'(axi.sop), 64'd1);
      get_pkt(next_tag + 32'd2, 64'h43, 1'b1);
      chk("co_no_drop", 64'(o_drop_cnt), 64'd1);
      next_tag += 32'd3;

      // Tag wrap
      @(negedge clk);
      force dut.seq_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.seq_q;
      strobe(8'h00);
      get_pkt(32'hFFFF_FFFF, 64'h0, 1'b0);
      strobe(8'h00);
      get_pkt(32'h0000_0000, 64'h0, 1'b0);

      // Async reset mid-beat0 under back-pressure
      axi.rdy = 1'b0;
      strobe(8'h05);
      chk("pre_rst_val", 64'(axi.val), 64'd1);
      #2 rst = 1'b1;
      #1 chk("async_val", 64'(axi.val), 64'd0);
      chk("async_drop", 64'(o_drop_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("no_resume", 64'(axi.val), 64'd0);
      chk("post_rst_busy", 64'(o_busy), 64'd0);
      axi.rdy = 1'b1;
      strobe(8'h02);
      get_pkt(32'h0, 64'h02, 1'b1);
      chk("post_rst_drop", 64'(o_drop_cnt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
